decode_stage: RTL and testbench
===============================

// Module: decode_stage
//
// PURPOSE
// Registered RV32I instruction decode stage with a valid/ready handshake on both sides.
// Sits between fetch and execute, turning {instr, pc} into a decoded bundle:
//   - one-hot op class
//   - pre-selected immediate
//   - register ids, funct3/funct7
//   - illegal flag
// Optional skid buffer gives full throughput with a registered in_ready. Optional M-extension mode.
//
// PARAMETERS
// XLEN   32  width of pc path (immediates stay 32-bit, sign-extended)
// SKID   1   1: 1-entry skid buffer, in_ready is a flop output; 0: in_ready = !out_valid || out_ready
// EN_M   0   1: ALUreg with funct7=0000001 is legal (MUL/DIV); 0: illegal
//
// PORTS
// clk         in   1     clock, rising edge
// resetn      in   1     asynchronous active-low reset
// flush       in   1     synchronous kill of all held instructions
// in_valid    in   1     upstream instr/pc valid
// in_ready    out  1     stage can accept
// in_instr    in   32    raw instruction
// in_pc       in   XLEN  instruction address
// out_valid   out  1     decoded bundle valid
// out_ready   in   1     downstream accepts
// out_pc      out  XLEN  pc of decoded instr
// out_op      out  10    one-hot class {SYSTEM,STORE,LOAD,LUI,AUIPC,JAL,JALR,BRANCH,ALUIMM,ALUREG}
// out_imm     out  32    immediate chosen by class (I/S/B/U/J), 0 for ALUREG/SYSTEM
// out_rs1     out  5     instr[19:15]
// out_rs2     out  5     instr[24:20]
// out_rd      out  5     instr[11:7]
// out_funct3  out  3     instr[14:12]
// out_funct7  out  7     instr[31:25]
// out_illegal out  1     instruction not legal in current mode
//
// BEHAVIOUR
// - Reset (resetn=0): out_valid=0, in_ready=0, all out_* data=0, skid empty.
//   in_ready rises the first cycle after reset release.
// - Latency: 1 cycle from accept (in_valid&&in_ready) to out_valid. Throughput: 1/cycle.
// - Handshake: while out_valid && !out_ready, every out_* stays stable.
//   in_valid with in_ready=0 is ignored: no side effect.
// - States (SKID=1):
//   EMPTY: out_valid=0, in_ready=1. Accept -> HOLD.
//   HOLD: out reg full, skid empty, in_ready=1.
//     - accept & !out_ready -> SKIDFULL (new bundle into skid)
//     - out_ready & !accept -> EMPTY
//     - both -> HOLD (out reg reloads)
//   SKIDFULL: in_ready=0.
//     - out_ready -> HOLD; skid moves to out reg the same cycle.
// - SKID=0: only EMPTY/HOLD; out reg loads on accept, order preserved.
// - flush=1: next state EMPTY; out_valid=0 and skid cleared next cycle.
//   An accept in the flush cycle is dropped. flush overrides all other transitions.
// - Decode: legal requires instr[1:0]=2'b11 and opcode[6:2] in the 10 classes.
//   ALUREG funct7 must be:
//     - 0000000
//     - 0100000 only with funct3 000/101
//     - 0000001 only if EN_M
//   SYSTEM decodes as SYSTEM regardless of funct3.
// - Illegal bundle: out_op=0, out_illegal=1, fields still raw, out_imm=0. Passes through like any other.
// - Immediates: sign-extended from instr[31].
//   I={20{i31},i[31:20]}
//   S={20{i31},i[31:25],i[11:7]}
//   B={19{i31},i31,i7,i[30:25],i[11:8],0}
//   U={i[31:12],12'b0}
//   J={11{i31},i31,i[19:12],i20,i[30:21],0}
// - Mid-operation reset: held and skid bundles discarded, outputs back to reset values immediately.
//
// STRUCTURE
// - Shared package rv_pkg:
//   - opcode[6:2] localparams
//   - OP_* one-hot bit indices
//   - funct7 constants (F7_BASE, F7_ALT, F7_MULDIV)
//   - decoded-bundle width constant
// - One sub-module: instr_decode_comb (pure combinational instr -> bundle, EN_M param).
//   Top holds out reg, skid reg and the FSM.
//
// TESTING
// 1. in 0x00A50533 pc 0x100, out_ready=1 -> next cycle out_op=ALUREG, rs1=10, rs2=10, rd=10, out_pc=0x100, illegal=0.
// 2. 0xFE000EE3 -> BRANCH, out_imm=0xFFFFFFFC. 0x12345037 -> LUI, out_imm=0x12345000. 0x0000006F -> JAL, out_imm=0.
// 3. EN_M=0 vs 1, instr 0x02A50533 (MUL) -> illegal=1/op=0 vs illegal=0/op=ALUREG. 0x00000000 -> illegal=1 in both.
// 4. SKID=1: stream 4 instrs, out_ready=0 for 3 cycles
//    -> in_ready drops after 2 accepts, out_* stable, all 4 emerge in order, no loss or duplication.
// 5. flush in SKIDFULL with in_valid=1 -> next cycle out_valid=0, in_ready=1; dropped instr never appears.
// 6. resetn pulled low mid-stream asynchronously -> out_valid=0 same cycle; after release first output is a new accept.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcode classes, one-hot op indices,
// funct7 encodings, the decoded bundle type and the stage FSM states.
package rv_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_ALUIMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_ALUREG = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam int OP_ALUREG = 0;
  localparam int OP_ALUIMM = 1;
  localparam int OP_BRANCH = 2;
  localparam int OP_JALR   = 3;
  localparam int OP_JAL    = 4;
  localparam int OP_AUIPC  = 5;
  localparam int OP_LUI    = 6;
  localparam int OP_LOAD   = 7;
  localparam int OP_STORE  = 8;
  localparam int OP_SYSTEM = 9;
  localparam int NUM_OPS   = 10;

  // Opcode for one-hot bit i lives at [i*5 +: 5].
  localparam logic [NUM_OPS*5-1:0] OPC_TABLE = {
    OPC_SYSTEM, OPC_STORE, OPC_LOAD, OPC_LUI, OPC_AUIPC,
    OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_ALUIMM, OPC_ALUREG
  };

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [NUM_OPS-1:0] op;
    logic [31:0]        imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               illegal;
  } dec_bundle_t;

  localparam int DEC_W = $bits(dec_bundle_t);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_HOLD     = 2'd1,
    ST_SKIDFULL = 2'd2
  } stage_state_t;

endpackage

// File: rtl/instr_decode_comb.sv
// Pure combinational RV32I decode of one instruction word into a bundle.
// Illegal words produce op=0 and imm=0 but keep the raw register/funct fields.
module instr_decode_comb
  import rv_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0] instr,
  output dec_bundle_t bundle
);

  logic [NUM_OPS-1:0] class_hit;
  logic               f7_ok;
  logic               legal;
  logic [31:0]        imm_i;
  logic [31:0]        imm_s;
  logic [31:0]        imm_b;
  logic [31:0]        imm_u;
  logic [31:0]        imm_j;
  logic [31:0]        imm_sel;

  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_class
    assign class_hit[gi] = (instr[6:2] == OPC_TABLE[gi*5 +: 5]);
  end

  always_comb begin
    f7_ok = 1'b0;
    case (instr[31:25])
      F7_BASE:   f7_ok = 1'b1;
      F7_ALT:    f7_ok = (instr[14:12] == 3'b000) || (instr[14:12] == 3'b101);
      F7_MULDIV: f7_ok = EN_M;
      default:   f7_ok = 1'b0;
    endcase
  end

  // funct7 only constrains register-register ALU ops; other classes ignore it.
  assign legal = (instr[1:0] == 2'b11) && (|class_hit) &&
                 (!class_hit[OP_ALUREG] || f7_ok);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    imm_sel = '0;
    if (class_hit[OP_ALUIMM] || class_hit[OP_JALR] || class_hit[OP_LOAD]) begin
      imm_sel = imm_i;
    end else if (class_hit[OP_STORE]) begin
      imm_sel = imm_s;
    end else if (class_hit[OP_BRANCH]) begin
      imm_sel = imm_b;
    end else if (class_hit[OP_LUI] || class_hit[OP_AUIPC]) begin
      imm_sel = imm_u;
    end else if (class_hit[OP_JAL]) begin
      imm_sel = imm_j;
    end
  end

  always_comb begin
    bundle         = '0;
    bundle.op      = legal ? class_hit : '0;
    bundle.imm     = legal ? imm_sel : 32'd0;
    bundle.rs1     = instr[19:15];
    bundle.rs2     = instr[24:20];
    bundle.rd      = instr[11:7];
    bundle.funct3  = instr[14:12];
    bundle.funct7  = instr[31:25];
    bundle.illegal = !legal;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready on both sides and an
// optional one-entry skid buffer so in_ready can come straight from a flop.
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1,
  parameter bit EN_M = 1'b0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [NUM_OPS-1:0] out_op,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_illegal
);

  dec_bundle_t     dec;
  dec_bundle_t     out_bundle_reg;
  dec_bundle_t     skid_bundle_reg;
  logic [XLEN-1:0] out_pc_reg;
  logic [XLEN-1:0] skid_pc_reg;
  stage_state_t    state_reg;
  logic            in_ready_reg;
  logic            accept;

  instr_decode_comb #(
    .EN_M(EN_M)
  ) u_decode (
    .instr (in_instr),
    .bundle(dec)
  );

  // in_ready_reg is low during reset and in SKIDFULL; without a skid it
  // additionally needs the output slot to be free or draining this cycle.
  if (SKID) begin : g_skid_ready
    assign in_ready = in_ready_reg;
  end else begin : g_direct_ready
    assign in_ready = in_ready_reg && ((state_reg != ST_HOLD) || out_ready);
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= ST_EMPTY;
      in_ready_reg    <= 1'b0;
      out_bundle_reg  <= '0;
      skid_bundle_reg <= '0;
      out_pc_reg      <= '0;
      skid_pc_reg     <= '0;
    end else if (flush) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          in_ready_reg <= 1'b1;
          if (accept) begin
            out_bundle_reg <= dec;
            out_pc_reg     <= in_pc;
            state_reg      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (accept && out_ready) begin
            out_bundle_reg <= dec;
            out_pc_reg     <= in_pc;
          end else if (accept) begin
            // Only reachable with a skid buffer: downstream stalled while
            // the registered in_ready was still high.
            skid_bundle_reg <= dec;
            skid_pc_reg     <= in_pc;
            state_reg       <= ST_SKIDFULL;
            in_ready_reg    <= 1'b0;
          end else if (out_ready) begin
            state_reg <= ST_EMPTY;
          end
        end
        ST_SKIDFULL: begin
          if (out_ready) begin
            out_bundle_reg <= skid_bundle_reg;
            out_pc_reg     <= skid_pc_reg;
            state_reg      <= ST_HOLD;
            in_ready_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg    <= ST_EMPTY;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid   = (state_reg != ST_EMPTY);
  assign out_pc      = out_pc_reg;
  assign out_op      = out_bundle_reg.op;
  assign out_imm     = out_bundle_reg.imm;
  assign out_rs1     = out_bundle_reg.rs1;
  assign out_rs2     = out_bundle_reg.rs2;
  assign out_rd      = out_bundle_reg.rd;
  assign out_funct3  = out_bundle_reg.funct3;
  assign out_funct7  = out_bundle_reg.funct7;
  assign out_illegal = out_bundle_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: u0 is SKID=1/EN_M=0, u1 is SKID=0/EN_M=1.
// Directed decode table plus stall, flush and async-reset sequences.
module tb_decode_stage;

  localparam logic [9:0] C_ALUREG = 10'h001;
  localparam logic [9:0] C_ALUIMM = 10'h002;
  localparam logic [9:0] C_BRANCH = 10'h004;
  localparam logic [9:0] C_JALR   = 10'h008;
  localparam logic [9:0] C_JAL    = 10'h010;
  localparam logic [9:0] C_AUIPC  = 10'h020;
  localparam logic [9:0] C_LUI    = 10'h040;
  localparam logic [9:0] C_LOAD   = 10'h080;
  localparam logic [9:0] C_STORE  = 10'h100;
  localparam logic [9:0] C_SYSTEM = 10'h200;
  localparam int NV = 18;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [9:0]  op0;
    logic        ill0;
    logic [9:0]  op1;
    logic        ill1;
    logic [31:0] imm;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  in_valid = 2'b00;
  logic [1:0]  out_ready = 2'b00;
  logic [31:0] in_instr [2];
  logic [31:0] in_pc [2];
  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic [1:0]  out_illegal;
  logic [31:0] out_pc [2];
  logic [31:0] out_imm [2];
  logic [9:0]  out_op [2];
  logic [4:0]  out_rs1 [2];
  logic [4:0]  out_rs2 [2];
  logic [4:0]  out_rd [2];
  logic [2:0]  out_funct3 [2];
  logic [6:0]  out_funct7 [2];

  int checks = 0;
  int failures = 0;
  vec_t vec [NV];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SKID(1'b1), .EN_M(1'b0)) u0 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_instr(in_instr[0]), .in_pc(in_pc[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_pc(out_pc[0]), .out_op(out_op[0]), .out_imm(out_imm[0]),
    .out_rs1(out_rs1[0]), .out_rs2(out_rs2[0]), .out_rd(out_rd[0]),
    .out_funct3(out_funct3[0]), .out_funct7(out_funct7[0]),
    .out_illegal(out_illegal[0])
  );

  decode_stage #(.XLEN(32), .SKID(1'b0), .EN_M(1'b1)) u1 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_instr(in_instr[1]), .in_pc(in_pc[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_pc(out_pc[1]), .out_op(out_op[1]), .out_imm(out_imm[1]),
    .out_rs1(out_rs1[1]), .out_rs2(out_rs2[1]), .out_rd(out_rd[1]),
    .out_funct3(out_funct3[1]), .out_funct7(out_funct7[1]),
    .out_illegal(out_illegal[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_both(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = v;
      in_instr[d] = instr;
      in_pc[d]    = pc;
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input int idx,
                              input logic [9:0] op0, input logic ill0,
                              input logic [9:0] op1, input logic ill1,
                              input logic [31:0] imm);
    vec_t v;
    v.instr = instr;
    v.pc    = 32'h100 + 32'(idx) * 4;
    v.op0   = op0;
    v.ill0  = ill0;
    v.op1   = op1;
    v.ill1  = ill1;
    v.imm   = imm;
    return v;
  endfunction

  task automatic check_vec(input int k);
    logic [31:0] w;
    logic [9:0]  eop;
    logic        eill;
    w = vec[k].instr;
    for (int d = 0; d < 2; d++) begin
      eop  = (d == 0) ? vec[k].op0 : vec[k].op1;
      eill = (d == 0) ? vec[k].ill0 : vec[k].ill1;
      check($sformatf("v%0d_u%0d_valid", k, d), out_valid[d], 1'b1);
      check($sformatf("v%0d_u%0d_op", k, d), out_op[d], eop);
      check($sformatf("v%0d_u%0d_illegal", k, d), out_illegal[d], eill);
      check($sformatf("v%0d_u%0d_imm", k, d), out_imm[d], eill ? 32'd0 : vec[k].imm);
      check($sformatf("v%0d_u%0d_pc", k, d), out_pc[d], vec[k].pc);
      check($sformatf("v%0d_u%0d_rs1", k, d), out_rs1[d], w[19:15]);
      check($sformatf("v%0d_u%0d_rs2", k, d), out_rs2[d], w[24:20]);
      check($sformatf("v%0d_u%0d_rd", k, d), out_rd[d], w[11:7]);
      check($sformatf("v%0d_u%0d_f3", k, d), out_funct3[d], w[14:12]);
      check($sformatf("v%0d_u%0d_f7", k, d), out_funct7[d], w[31:25]);
    end
    $display("vec %0d instr=%08h pc=%0h u0 op=%03h ill=%0b imm=%08h | u1 op=%03h ill=%0b",
             k, w, out_pc[0], out_op[0], out_illegal[0], out_imm[0], out_op[1], out_illegal[1]);
  endtask

  initial begin
    logic [31:0] got0 [$];
    logic [31:0] got1 [$];
    int          sent [2];
    bit          stall_prev;
    bit          drop_chk;
    bit          seen;
    logic [31:0] prev_pc;
    logic [4:0]  prev_rd;

    vec[0]  = mk(32'h00A50533, 0,  C_ALUREG, 0, C_ALUREG, 0, 32'h0);
    vec[1]  = mk(32'hFE000EE3, 1,  C_BRANCH, 0, C_BRANCH, 0, 32'hFFFFFFFC);
    vec[2]  = mk(32'h12345037, 2,  C_LUI,    0, C_LUI,    0, 32'h12345000);
    vec[3]  = mk(32'h0000006F, 3,  C_JAL,    0, C_JAL,    0, 32'h0);
    vec[4]  = mk(32'h02A50533, 4,  10'h0,    1, C_ALUREG, 0, 32'h0);
    vec[5]  = mk(32'h00000000, 5,  10'h0,    1, 10'h0,    1, 32'h0);
    vec[6]  = mk(32'h40A50533, 6,  C_ALUREG, 0, C_ALUREG, 0, 32'h0);
    vec[7]  = mk(32'h40A51533, 7,  10'h0,    1, 10'h0,    1, 32'h0);
    vec[8]  = mk(32'h00002073, 8,  C_SYSTEM, 0, C_SYSTEM, 0, 32'h0);
    vec[9]  = mk(32'h00A12423, 9,  C_STORE,  0, C_STORE,  0, 32'h8);
    vec[10] = mk(32'hFFC0A283, 10, C_LOAD,   0, C_LOAD,   0, 32'hFFFFFFFC);
    vec[11] = mk(32'hFFF00093, 11, C_ALUIMM, 0, C_ALUIMM, 0, 32'hFFFFFFFF);
    vec[12] = mk(32'hFFFFF017, 12, C_AUIPC,  0, C_AUIPC,  0, 32'hFFFFF000);
    vec[13] = mk(32'h000080E7, 13, C_JALR,   0, C_JALR,   0, 32'h0);
    vec[14] = mk(32'hFFDFF06F, 14, C_JAL,    0, C_JAL,    0, 32'hFFFFFFFC);
    vec[15] = mk(32'h00A50531, 15, 10'h0,    1, 10'h0,    1, 32'h0);
    vec[16] = mk(32'h0000000F, 16, 10'h0,    1, 10'h0,    1, 32'h0);
    vec[17] = mk(32'h02A54533, 17, 10'h0,    1, C_ALUREG, 0, 32'h0);

    drive_both(1'b0, 32'h0, 32'h0);

    // Reset state
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_u%0d_valid", d), out_valid[d], 1'b0);
      check($sformatf("rst_u%0d_in_ready", d), in_ready[d], 1'b0);
      check($sformatf("rst_u%0d_pc", d), out_pc[d], 32'h0);
      check($sformatf("rst_u%0d_op", d), out_op[d], 10'h0);
      check($sformatf("rst_u%0d_imm", d), out_imm[d], 32'h0);
      check($sformatf("rst_u%0d_illegal", d), out_illegal[d], 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rel_u0_in_ready_still_low", in_ready[0], 1'b0);
    @(negedge clk);
    check("rel_u0_in_ready_up", in_ready[0], 1'b1);
    check("rel_u1_in_ready_up", in_ready[1], 1'b1);

    // Decode table, back-to-back with out_ready=1
    out_ready = 2'b11;
    for (int i = 0; i <= NV; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check_vec(i - 1);
      end
      if (i < NV) drive_both(1'b1, vec[i].instr, vec[i].pc);
      else drive_both(1'b0, 32'h0, 32'h0);
    end
    @(negedge clk);
    check("drain_u0_valid", out_valid[0], 1'b0);

    // Stall sequence: 4 instrs, out_ready low for the first 3 cycles
    sent = '{0, 0};
    stall_prev = 1'b0;
    drop_chk = 1'b0;
    prev_pc = '0;
    prev_rd = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (stall_prev) begin
        check($sformatf("stall_c%0d_pc_stable", c), out_pc[0], prev_pc);
        check($sformatf("stall_c%0d_rd_stable", c), out_rd[0], prev_rd);
      end
      for (int d = 0; d < 2; d++) begin
        out_ready[d] = (c >= 3);
        in_valid[d]  = (sent[d] < 4);
        in_instr[d]  = 32'h00000013 | (32'(sent[d] + 1) << 7);
        in_pc[d]     = 32'h200 + 32'(sent[d]) * 4;
      end
      #1;
      if (sent[0] == 2 && !out_ready[0] && !drop_chk) begin
        check("skid_in_ready_low", in_ready[0], 1'b0);
        drop_chk = 1'b1;
      end
      if (out_valid[0] && out_ready[0]) got0.push_back(out_pc[0]);
      if (out_valid[1] && out_ready[1]) got1.push_back(out_pc[1]);
      stall_prev = out_valid[0] && !out_ready[0];
      prev_pc = out_pc[0];
      prev_rd = out_rd[0];
      for (int d = 0; d < 2; d++) if (in_valid[d] && in_ready[d]) sent[d]++;
    end
    check("skid_drop_seen", drop_chk, 1'b1);
    check("stream_u0_count", got0.size(), 4);
    check("stream_u1_count", got1.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < got0.size()) check($sformatf("stream_u0_pc%0d", k), got0[k], 32'h200 + 32'(k) * 4);
      if (k < got1.size()) check($sformatf("stream_u1_pc%0d", k), got1[k], 32'h200 + 32'(k) * 4);
      $display("stream item %0d u0 pc=%0h u1 pc=%0h", k,
               (k < got0.size()) ? got0[k] : 32'hx, (k < got1.size()) ? got1[k] : 32'hx);
    end

    // Flush while SKIDFULL with a pending input
    @(negedge clk);
    out_ready = 2'b00;
    drive_both(1'b1, 32'h00100093, 32'h300);
    @(negedge clk);
    drive_both(1'b1, 32'h00200093, 32'h304);
    @(negedge clk);
    check("flush_pre_in_ready_low", in_ready[0], 1'b0);
    drive_both(1'b1, 32'h00300093, 32'h308);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive_both(1'b0, 32'h0, 32'h0);
    check("flush_u0_valid", out_valid[0], 1'b0);
    check("flush_u0_in_ready", in_ready[0], 1'b1);
    check("flush_u1_valid", out_valid[1], 1'b0);
    out_ready = 2'b11;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid[0] || out_valid[1]) seen = 1'b1;
    end
    check("flush_no_ghost", seen, 1'b0);
    $display("flush from SKIDFULL done");

    // Flush in HOLD with a same-cycle accept: the accepted instr is dropped
    out_ready = 2'b00;
    drive_both(1'b1, 32'h00400093, 32'h30C);
    @(negedge clk);
    check("hflush_u0_in_ready", in_ready[0], 1'b1);
    drive_both(1'b1, 32'h00500093, 32'h310);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive_both(1'b0, 32'h0, 32'h0);
    check("hflush_u0_valid", out_valid[0], 1'b0);
    out_ready = 2'b11;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    check("hflush_dropped", seen, 1'b0);
    $display("flush from HOLD done");

    // Asynchronous reset mid-stream
    drive_both(1'b1, 32'h00600093, 32'h400);
    @(negedge clk);
    drive_both(1'b1, 32'h00700093, 32'h404);
    check("arst_pre_valid", out_valid[0], 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_u0_valid", out_valid[0], 1'b0);
    check("arst_u0_in_ready", in_ready[0], 1'b0);
    check("arst_u0_pc", out_pc[0], 32'h0);
    check("arst_u1_valid", out_valid[1], 1'b0);
    drive_both(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("arst_rel_in_ready", in_ready[0], 1'b1);
    check("arst_rel_valid", out_valid[0], 1'b0);
    drive_both(1'b1, 32'h00800093, 32'h408);
    @(negedge clk);
    drive_both(1'b0, 32'h0, 32'h0);
    check("arst_first_valid", out_valid[0], 1'b1);
    check("arst_first_pc", out_pc[0], 32'h408);
    check("arst_first_pc_u1", out_pc[1], 32'h408);
    @(negedge clk);
    check("arst_after_valid", out_valid[0], 1'b0);
    $display("async reset sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
